// File: rtl/ex_mem_buffer_pkg.sv
// Shared types for the EX/MEM pipeline buffer: ALU op encoding, decoded control
// bits and the entry handed to the memory stage.
package ex_mem_buffer_pkg;

   localparam int XLEN_PKG = 64;

   typedef enum logic [4:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
      ALU_SLT, ALU_SLTU, ALU_LUI, ALU_AUIPC,
      ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU,
      ALU_JAL, ALU_JALR
   } aluop_e;

   typedef struct packed {
      aluop_e     aluop;
      logic       usign;
      logic       memread;
      logic       memwrite;
      logic       regwrite;
      logic [4:0] rd;
   } control_bits;

   typedef struct packed {
      logic [XLEN_PKG-1:0] result;
      logic [XLEN_PKG-1:0] store_data;
      logic [4:0]          rd;
      logic                memread;
      logic                memwrite;
      logic                regwrite;
      logic                usign;
      logic [XLEN_PKG-1:0] pc;
   } ex_mem_entry_t;

   // Conditional branches rely on contiguous BEQ..BGEU encodings.
   function automatic logic is_taken(input aluop_e op, input logic take);
      return ((op >= ALU_BEQ) && (op <= ALU_BGEU) && take) ||
             (op == ALU_JAL) || (op == ALU_JALR);
   endfunction

endpackage

// File: rtl/ex_mem_buffer_fifo.sv
// Small FIFO holding EX/MEM entries; head entry is read straight from storage
// registers so the output has no combinational path from the inputs.
module ex_mem_fifo
   import ex_mem_buffer_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  logic          pop_i,
   input  ex_mem_entry_t entry_i,
   output ex_mem_entry_t entry_o,
   output logic          ready_o,
   output logic          valid_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   ex_mem_entry_t mem_q [DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign ready_o = (count_q < FULL);
   assign valid_o = (count_q != '0);
   assign do_push = push_i && ready_o;
   assign do_pop  = pop_i && valid_o;
   assign entry_o = mem_q[head_q];

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (do_push) tail_d = (tail_q == LAST) ? '0 : tail_q + 1'b1;
      if (do_pop)  head_d = (head_q == LAST) ? '0 : head_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload storage is deliberately left out of reset; valid_o guards it.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[tail_q] <= entry_i;
   end

endmodule

// File: rtl/ex_mem_buffer.sv
// EX/MEM pipeline buffer: queues execute results for the memory stage and
// raises a one-cycle front-end redirect for taken branches and jumps.
module ex_mem_buffer
   import ex_mem_buffer_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int XLEN  = 64
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_result,
   input  logic            in_take_branch,
   input  control_bits     in_ctrl,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_br_target,
   input  logic [XLEN-1:0] in_store_data,
   output logic            out_valid,
   input  logic            out_ready,
   output ex_mem_entry_t   out_entry,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
);

   logic            push, pop, taken, is_jump;
   logic            redirect_valid_q, redirect_valid_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
   ex_mem_entry_t   entry_d;

   // While a redirect is in flight the incoming instruction is wrong-path.
   assign push    = in_valid && in_ready && !redirect_valid_q;
   assign pop     = out_valid && out_ready;
   assign is_jump = (in_ctrl.aluop == ALU_JAL) || (in_ctrl.aluop == ALU_JALR);
   assign taken   = is_taken(in_ctrl.aluop, in_take_branch);

   always_comb begin
      entry_d            = '0;
      entry_d.result     = is_jump ? (in_pc + XLEN'(4)) : in_result;
      entry_d.store_data = in_store_data;
      entry_d.rd         = in_ctrl.rd;
      entry_d.memread    = in_ctrl.memread;
      entry_d.memwrite   = in_ctrl.memwrite;
      entry_d.regwrite   = in_ctrl.regwrite;
      entry_d.usign      = in_ctrl.usign;
      entry_d.pc         = in_pc;
   end

   always_comb begin
      redirect_valid_d = push && taken;
      redirect_pc_d    = redirect_pc_q;
      if (redirect_valid_d)
         redirect_pc_d = (in_ctrl.aluop == ALU_JALR) ? in_result : in_br_target;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
      end
   end

   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;

   ex_mem_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (reset_n),
      .push_i  (push),
      .pop_i   (pop),
      .entry_i (entry_d),
      .entry_o (out_entry),
      .ready_o (in_ready),
      .valid_o (out_valid)
   );

endmodule

// File: tb/tb_ex_mem_buffer.sv
// Bench for ex_mem_buffer: directed scenarios then random traffic, checked
// against a queue-based reference model of the buffer and redirect rules.
module tb_ex_mem_buffer;
   import ex_mem_buffer_pkg::*;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [63:0]   in_result = '0;
   logic          in_take_branch = 1'b0;
   control_bits   in_ctrl = '0;
   logic [63:0]   in_pc = '0;
   logic [63:0]   in_br_target = '0;
   logic [63:0]   in_store_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   ex_mem_entry_t out_entry;
   logic          redirect_valid;
   logic [63:0]   redirect_pc;

   int checks = 0;
   int errors = 0;

   ex_mem_entry_t exp_q [$];
   logic          exp_rv = 1'b0;
   logic [63:0]   exp_rpc = '0;

   aluop_e ops [20] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
                        ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_LUI, ALU_AUIPC,
                        ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU,
                        ALU_JAL, ALU_JALR};

   ex_mem_buffer #(.DEPTH(2), .XLEN(64)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_result      (in_result),
      .in_take_branch (in_take_branch),
      .in_ctrl        (in_ctrl),
      .in_pc          (in_pc),
      .in_br_target   (in_br_target),
      .in_store_data  (in_store_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_entry      (out_entry),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic bit is_branch(input aluop_e op);
      return op inside {ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
   endfunction

   task automatic set_in(input logic v, input aluop_e op, input logic tk,
                         input logic [63:0] res, input logic [63:0] pc, input logic [63:0] tgt);
      in_valid         = v;
      in_ctrl.aluop    = op;
      in_take_branch   = tk;
      in_result        = res;
      in_pc            = pc;
      in_br_target     = tgt;
      in_store_data    = {$urandom, $urandom};
      in_ctrl.rd       = 5'($urandom);
      in_ctrl.usign    = 1'($urandom);
      in_ctrl.memread  = is_branch(op) ? 1'b0 : 1'($urandom);
      in_ctrl.memwrite = is_branch(op) ? 1'b0 : 1'($urandom);
      in_ctrl.regwrite = !is_branch(op);
   endtask

   // Compare outputs against the model, then advance the model by one clock.
   task automatic step(input string tag);
      bit            rdy, push, pop, tk;
      ex_mem_entry_t ent;
      @(negedge clk);
      chk({tag, ".in_ready"}, in_ready, exp_q.size() < 2);
      chk({tag, ".out_valid"}, out_valid, exp_q.size() > 0);
      chk({tag, ".redirect_valid"}, redirect_valid, exp_rv);
      if (exp_rv) chk({tag, ".redirect_pc"}, redirect_pc, exp_rpc);
      if (exp_q.size() > 0) chk({tag, ".out_entry"}, out_entry, exp_q[0]);
      rdy  = exp_q.size() < 2;
      push = in_valid && rdy && !exp_rv;
      pop  = (exp_q.size() > 0) && out_ready;
      tk   = (is_branch(in_ctrl.aluop) && in_take_branch) ||
             in_ctrl.aluop == ALU_JAL || in_ctrl.aluop == ALU_JALR;
      ent.result     = (in_ctrl.aluop == ALU_JAL || in_ctrl.aluop == ALU_JALR) ? in_pc + 64'd4 : in_result;
      ent.store_data = in_store_data;
      ent.rd         = in_ctrl.rd;
      ent.memread    = in_ctrl.memread;
      ent.memwrite   = in_ctrl.memwrite;
      ent.regwrite   = in_ctrl.regwrite;
      ent.usign      = in_ctrl.usign;
      ent.pc         = in_pc;
      if (pop) void'(exp_q.pop_front());
      if (push) exp_q.push_back(ent);
      exp_rv = push && tk;
      if (push && tk) exp_rpc = (in_ctrl.aluop == ALU_JALR) ? in_result : in_br_target;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst.out_valid", out_valid, 1'b0);
      chk("rst.redirect_valid", redirect_valid, 1'b0);
      chk("rst.redirect_pc", redirect_pc, 64'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst.in_ready", in_ready, 1'b1);

      // Simple ADD push
      out_ready = 1'b1;
      set_in(1'b1, ALU_ADD, 1'b0, 64'h5, 64'h100, 64'h0);
      step("add0");
      chk("add.out_valid", out_valid, 1'b1);
      chk("add.result", out_entry.result, 64'h5);
      chk("add.redirect", redirect_valid, 1'b0);
      in_valid = 1'b0;
      step("add1");
      step("add2");

      // Back-pressure: third push held until the consumer drains
      out_ready = 1'b0;
      set_in(1'b1, ALU_ADD, 1'b0, 64'h11, 64'h110, 64'h0);
      step("bp0");
      set_in(1'b1, ALU_SUB, 1'b0, 64'h12, 64'h114, 64'h0);
      step("bp1");
      set_in(1'b1, ALU_OR, 1'b0, 64'h13, 64'h118, 64'h0);
      chk("bp.in_ready_full", in_ready, 1'b0);
      step("bp2");
      out_ready = 1'b1;
      step("bp3");
      chk("bp.second_head", out_entry.result, 64'h12);
      step("bp4");
      in_valid = 1'b0;
      step("bp5");
      step("bp6");

      // Taken BEQ, following push is dropped
      set_in(1'b1, ALU_BEQ, 1'b1, 64'h0, 64'h300, 64'h1000);
      step("beq0");
      chk("beq.redirect_valid", redirect_valid, 1'b1);
      chk("beq.redirect_pc", redirect_pc, 64'h1000);
      chk("beq.regwrite", out_entry.regwrite, 1'b0);
      set_in(1'b1, ALU_ADD, 1'b0, 64'h77, 64'h304, 64'h0);
      step("beq1");
      chk("beq.pulse_end", redirect_valid, 1'b0);
      in_valid = 1'b0;
      step("beq2");
      step("beq3");

      // JALR link value and target
      out_ready = 1'b0;
      set_in(1'b1, ALU_JALR, 1'b0, 64'h3000, 64'h200, 64'hdead);
      step("jalr0");
      chk("jalr.redirect_pc", redirect_pc, 64'h3000);
      chk("jalr.link", out_entry.result, 64'h204);
      in_valid = 1'b0;
      out_ready = 1'b1;
      step("jalr1");
      step("jalr2");

      // Full buffer with pop and in_valid together
      out_ready = 1'b0;
      set_in(1'b1, ALU_ADD, 1'b0, 64'h21, 64'h400, 64'h0);
      step("full0");
      set_in(1'b1, ALU_ADD, 1'b0, 64'h22, 64'h404, 64'h0);
      step("full1");
      set_in(1'b1, ALU_ADD, 1'b0, 64'h23, 64'h408, 64'h0);
      out_ready = 1'b1;
      step("full2");
      chk("full.in_ready_after", in_ready, 1'b1);
      chk("full.head", out_entry.result, 64'h22);
      in_valid = 1'b0;
      step("full3");
      step("full4");
      step("full5");

      // Reset mid-operation with two entries and a redirect pending
      out_ready = 1'b0;
      set_in(1'b1, ALU_ADD, 1'b0, 64'h31, 64'h500, 64'h0);
      step("mrst0");
      set_in(1'b1, ALU_JAL, 1'b0, 64'h0, 64'h504, 64'h5000);
      step("mrst1");
      chk("mrst.pending", redirect_valid, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("mrst.out_valid", out_valid, 1'b0);
      chk("mrst.redirect_valid", redirect_valid, 1'b0);
      chk("mrst.redirect_pc", redirect_pc, 64'h0);
      exp_q.delete();
      exp_rv = 1'b0;
      exp_rpc = '0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      step("mrst2");
      step("mrst3");
      step("mrst4");

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         set_in(($urandom % 4) != 0, ops[$urandom_range(0, 19)], 1'($urandom),
                {$urandom, $urandom}, {32'h0, $urandom & 32'hffff_fffc}, {$urandom, $urandom});
         out_ready = ($urandom % 3) != 0;
         step("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_mem_buffer.md
EX_MEM_BUFFER -- requirements
Module: ex_mem_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning buffer entry count; legal value is 2.
REQ-002 SHALL have parameter XLEN, default 64, meaning datapath width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, execute stage presents a result.
REQ-006 SHALL have port in_ready, output, 1, buffer accepts this cycle; driven from registered occupancy only.
REQ-007 SHALL have port in_result, input, XLEN, ALU result.
REQ-008 SHALL have port in_take_branch, input, 1, ALU branch condition.
REQ-009 SHALL have port in_ctrl, input, control_bits, decoded control (aluop, usign, memread, memwrite, regwrite, rd).
REQ-010 SHALL have port in_pc, input, XLEN, instruction PC.
REQ-011 SHALL have port in_br_target, input, XLEN, PC+immediate for branch/JAL.
REQ-012 SHALL have port in_store_data, input, XLEN, rs2 value for stores.
REQ-013 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_entry (output, ex_mem_entry_t) to the memory stage.
REQ-014 SHALL have ports redirect_valid (output, 1) and redirect_pc (output, XLEN), the front-end redirect.

Function
REQ-015 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-016 The buffer SHALL be a DEPTH-entry FIFO with head/tail pointers wrapping modulo DEPTH and a 0..DEPTH occupancy count.
REQ-017 in_ready SHALL be 1 iff count < DEPTH at the start of the cycle; a pop while full SHALL NOT raise in_ready in the same cycle.
REQ-018 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-019 out_valid SHALL be 1 iff count > 0; out_entry SHALL be the head entry, registered (zero combinational input-to-output paths).
REQ-020 On push, for aluop JAL or JALR the stored result SHALL be in_pc+4 (link value); otherwise in_result.
REQ-021 Taken condition: (aluop in BEQ..BGEU and in_take_branch) or aluop JAL or JALR.
REQ-022 On a taken push, redirect_valid SHALL pulse 1 for exactly the next cycle with redirect_pc = in_result for JALR (already LSB-cleared by the ALU), in_br_target otherwise.
REQ-023 A push arriving in the cycle redirect_valid is 1 SHALL be dropped (wrong-path flush): no entry written, no redirect, in_ready unaffected.
REQ-024 Branch entries (no regwrite, no memory op) SHALL still be buffered and presented to the memory stage with regwrite=0.
REQ-025 Popping from empty and pushing when full SHALL be impossible by construction; count SHALL never exceed DEPTH or underflow.

Reset
REQ-026 With reset_n low, asynchronously: count=0, pointers=0, out_valid=0, redirect_valid=0, redirect_pc=0, in_ready=1 after release; entry storage need not be cleared.
REQ-027 Reset asserted mid-operation SHALL discard all entries and any pending redirect pulse.

Structure
REQ-028 ex_mem_entry_t (result, store_data, rd, memread, memwrite, regwrite, usign, pc) SHALL be defined in the shared package beside control_bits and the aluop enum.
REQ-029 The FIFO storage/pointers SHALL be one sub-module, ex_mem_fifo; redirect logic stays in ex_mem_buffer.

Verification
REQ-030 After reset, push ADD result 0x5 with out_ready=1 -> out_valid next cycle, out_entry.result=0x5, no redirect.
REQ-031 out_ready=0, three back-to-back pushes -> first two accepted, in_ready=0 on cycle 3, third held; raising out_ready pops in order.
REQ-032 BEQ in_take_branch=1, in_br_target=0x1000 -> redirect_valid=1 one cycle, redirect_pc=0x1000; push that cycle dropped.
REQ-033 JALR in_pc=0x200, in_result=0x3000 -> redirect_pc=0x3000, stored result=0x204.
REQ-034 Full buffer with simultaneous pop and in_valid -> no push that cycle; in_ready=1 next cycle; count=1.
REQ-035 reset_n low while two entries held and redirect pending -> out_valid=0, redirect_valid=0 immediately, no entries emerge after release.
